// File: rtl/load_store_unit.sv
// load_store_unit
//   Executes one RV32I load or store per accepted request against a
//   word-addressed data memory whose completion latency is variable.
//   Stores are turned into byte-lane write enables plus lane-replicated
//   write data. Loads have their byte/half/word extracted from the
//   returned word and sign- or zero-extended.
//
// Parameters
//   TIMEOUT    cycles spent in ACCESS without mem_ack before faulting (>=1)
//
// Ports
//   clk        in   1   clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   req_valid  in   1   request strobe, sampled only in IDLE
//   req_load   in   1   1 = load, 0 = store
//   funct3     in   3   RV32I funct3
//   addr       in   32  byte address
//   wdata      in   32  store data (rs2)
//   busy       out  1   high whenever the unit is not IDLE
//   done       out  1   one-cycle completion pulse
//   fault      out  1   qualified by done: misaligned, illegal funct3, timeout
//   rdata      out  32  extended load result, held until the next load
//   mem_addr   out  32  word-aligned address of the latched request
//   mem_wdata  out  32  lane-replicated store data
//   mem_we     out  4   byte write enables (stores, ACCESS only)
//   mem_re     out  1   read strobe (loads, ACCESS only)
//   mem_ack    in   1   memory completion, mem_rdata valid same cycle
//   mem_rdata  in   32  read word
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_load,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  output logic        mem_re,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               load_q, load_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [1:0]         offs_q, offs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fault_q, fault_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [3:0]         we_q, we_d;

  // Illegal encodings and misaligned accesses never reach the memory.
  function automatic logic is_illegal(input logic ld, input logic [2:0] f3,
                                      input logic [1:0] o);
    logic bad;
    bad = 1'b0;
    if (ld) begin
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) bad = 1'b1;
    end else begin
      if (f3 >= 3'd3) bad = 1'b1;
    end
    if ((f3[1:0] == 2'b01) && o[0]) bad = 1'b1;          // LH/LHU/SH
    if ((f3[1:0] == 2'b10) && (o != 2'b00)) bad = 1'b1;  // LW/SW
    return bad;
  endfunction

  function automatic logic [3:0] store_lanes(input logic [2:0] f3,
                                             input logic [1:0] o);
    logic [3:0] we;
    case (f3[1:0])
      2'b00:   we = 4'b0001 << o;
      2'b01:   we = 4'b0011 << {o[1], 1'b0};
      default: we = 4'b1111;
    endcase
    return we;
  endfunction

  // Replicating the data across lanes lets the memory pick whichever
  // lanes the write enables select without any shifting.
  function automatic logic [31:0] store_data(input logic [2:0] f3,
                                             input logic [31:0] wd);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                               input logic [1:0] o,
                                               input logic [31:0] word);
    logic [31:0]        b_word;
    logic [31:0]        h_word;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        res;
    b_word = word >> {o, 3'b000};
    h_word = word >> {o[1], 4'b0000};
    b      = b_word[7:0];
    h      = h_word[15:0];
    case (f3)
      3'd0:    res = {{24{b[7]}}, b};
      3'd1:    res = {{16{h[15]}}, h};
      3'd4:    res = {24'd0, b};
      3'd5:    res = {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  always_comb begin
    state_d     = state_q;
    load_d      = load_q;
    funct3_d    = funct3_q;
    offs_d      = offs_q;
    cnt_d       = cnt_q;
    fault_d     = fault_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    we_d        = we_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          load_d      = req_load;
          funct3_d    = funct3;
          offs_d      = addr[1:0];
          mem_addr_d  = {addr[31:2], 2'b00};
          mem_wdata_d = store_data(funct3, wdata);
          we_d        = req_load ? 4'b0000 : store_lanes(funct3, addr[1:0]);
          cnt_d       = '0;
          if (is_illegal(req_load, funct3, addr[1:0])) begin
            fault_d = 1'b1;
            state_d = DONE;
          end else begin
            fault_d = 1'b0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          fault_d = 1'b0;
          if (load_q) rdata_d = load_extract(funct3_q, offs_q, mem_rdata);
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This was the TIMEOUT-th cycle without an ack.
          fault_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      load_q      <= 1'b0;
      funct3_q    <= 3'd0;
      offs_q      <= 2'd0;
      cnt_q       <= '0;
      fault_q     <= 1'b0;
      rdata_q     <= 32'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      we_q        <= 4'b0000;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      funct3_q    <= funct3_d;
      offs_q      <= offs_d;
      cnt_q       <= cnt_d;
      fault_q     <= fault_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      we_q        <= we_d;
    end
  end

  // Strobes are decoded from the registered state so they stay steady for
  // the whole ACCESS phase and drop at the edge that leaves it.
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign fault     = (state_q == DONE) && fault_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_re    = (state_q == ACCESS) && load_q;
  assign mem_we    = ((state_q == ACCESS) && !load_q) ? we_q : 4'b0000;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_load;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic        mem_re;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_load(req_load),
    .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .fault(fault), .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_fault", {31'd0, fault}, {31'd0, e.fault});
        check("done_rdata", rdata, e.rdata);
      end
    end
  end

  // One transaction. ack_dly < 0 means the memory never acknowledges.
  // exp_cyc is the expected number of ACCESS cycles (0 for illegal).
  task automatic do_req(input string name, input logic ld, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] word, input int ack_dly,
                        input logic exp_fault, input logic [31:0] exp_rd,
                        input logic [3:0] exp_we, input logic [31:0] exp_wd,
                        input int exp_cyc, input logic hold);
    exp_t e;
    int   cyc;
    @(negedge clk);
    req_valid = 1'b1;
    req_load  = ld;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    e.fault   = exp_fault;
    e.rdata   = exp_rd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    cyc = 0;
    while (busy && !done && cyc < 20) begin
      check({name, "_mem_re"}, {31'd0, mem_re}, {31'd0, ld});
      check({name, "_mem_we"}, {28'd0, mem_we}, {28'd0, exp_we});
      check({name, "_mem_addr"}, mem_addr, {a[31:2], 2'b00});
      if (!ld) check({name, "_mem_wdata"}, mem_wdata, exp_wd);
      if (cyc == ack_dly) begin
        mem_ack   = 1'b1;
        mem_rdata = word;
      end
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = 32'h5A5A5A5A;
      cyc++;
    end
    check({name, "_access_cycles"}, cyc, exp_cyc);
    check({name, "_done"}, {31'd0, done}, 32'd1);
    check({name, "_strobes_in_done"}, {27'd0, mem_re, mem_we}, 32'd0);
    @(posedge clk);
    #1;
    check({name, "_idle_after_done"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_load  = 1'b0;
    funct3    = 3'd0;
    addr      = 32'd0;
    wdata     = 32'd0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {27'd0, busy, done, fault, mem_re, 1'b0}, 32'd0);
    check("rst_we", {28'd0, mem_we}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Legal loads
    do_req("lw",  1, 3'd2, 32'h100, 0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 4'b0000, 0, 1, 0);
    do_req("lb",  1, 3'd0, 32'h103, 0, 32'h80112233, 0, 0, 32'hFFFFFF80, 4'b0000, 0, 1, 0);
    do_req("lbu", 1, 3'd4, 32'h103, 0, 32'h80112233, 1, 0, 32'h00000080, 4'b0000, 0, 2, 0);
    do_req("lhu", 1, 3'd5, 32'h102, 0, 32'h80112233, 0, 0, 32'h00008011, 4'b0000, 0, 1, 0);
    do_req("lh",  1, 3'd1, 32'h102, 0, 32'h80112233, 2, 0, 32'hFFFF8011, 4'b0000, 0, 3, 0);
    do_req("lh0", 1, 3'd1, 32'h100, 0, 32'h0000F00D, 0, 0, 32'hFFFFF00D, 4'b0000, 0, 1, 0);
    // Stores leave rdata untouched
    do_req("sb",  0, 3'd0, 32'h201, 32'h000000AB, 0, 0, 0, 32'hFFFFF00D, 4'b0010, 32'hABABABAB, 1, 0);
    do_req("sh",  0, 3'd1, 32'h202, 32'h00001234, 0, 1, 0, 32'hFFFFF00D, 4'b1100, 32'h12341234, 2, 0);
    do_req("sw",  0, 3'd2, 32'h300, 32'hCAFEF00D, 0, 0, 0, 32'hFFFFF00D, 4'b1111, 32'hCAFEF00D, 1, 0);
    // Illegal: no strobe, fault one cycle after accept
    do_req("sw_mis",  0, 3'd2, 32'h302, 32'h11111111, 0, 0, 1, 32'hFFFFF00D, 4'b0000, 0, 0, 0);
    do_req("lw_f3_3", 1, 3'd3, 32'h100, 0, 0, 0, 1, 32'hFFFFF00D, 4'b0000, 0, 0, 0);
    do_req("lh_mis",  1, 3'd1, 32'h101, 0, 0, 0, 1, 32'hFFFFF00D, 4'b0000, 0, 0, 0);
    do_req("st_f3_3", 0, 3'd3, 32'h200, 32'h1, 0, 0, 1, 32'hFFFFF00D, 4'b0000, 0, 0, 0);
    // Timeout: strobe held TO cycles, rdata unchanged
    do_req("lw_to", 1, 3'd2, 32'h500, 0, 32'h12345678, -1, 1, 32'hFFFFF00D, 4'b0000, 0, TO, 0);
    // req_valid held high: re-accept only after the IDLE cycle
    do_req("lw_hold", 1, 3'd2, 32'h400, 0, 32'h11223344, 3, 0, 32'h11223344, 4'b0000, 0, 4, 1);
    do_req("lbu_2nd", 1, 3'd4, 32'h401, 0, 32'h11223344, 0, 0, 32'h00000033, 4'b0000, 0, 1, 0);

    // Reset in the middle of ACCESS: strobe drops, no done pulse
    @(negedge clk);
    req_valid = 1'b1;
    req_load  = 1'b1;
    funct3    = 3'd2;
    addr      = 32'h600;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("mid_rst_re_before", {31'd0, mem_re}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_re_after", {31'd0, mem_re}, 32'd0);
    check("mid_rst_busy", {30'd0, busy, done}, 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("no_done_after_rst", {31'd0, done}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
